// File: rtl/fp_pkg.sv
// Floating-point format presets and constants shared by the FP datapath blocks.
package fp_pkg;

  localparam int SP_PRECISION = 32;
  localparam int SP_EXPONENT  = 8;
  localparam int SP_FRACTION  = 23;

  localparam int DP_PRECISION = 64;
  localparam int DP_EXPONENT  = 11;
  localparam int DP_FRACTION  = 52;

  localparam logic [31:0] FP_ONE_32 = 32'h3F800000;
  localparam logic [63:0] FP_ZERO   = '0;

  typedef enum logic {
    FP_SINGLE = 1'b0,
    FP_DOUBLE = 1'b1
  } fp_fmt_e;

  function automatic int precision_of(input fp_fmt_e fmt);
    return (fmt == FP_DOUBLE) ? DP_PRECISION : SP_PRECISION;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: combinational grant scanning upward from ptr+1.
// Pointer moves to the winner on a grant and holds otherwise; en low blocks all grants.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  int               pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    pos       = 0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      pos  = (int'(ptr) + k) % N;
      cand = pos[IDX_W-1:0];
      if (en && !grant_vld && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_vld   = 1'b1;
      end
    end
  end

  // Grant implies the request was set, so every grant is a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= IDX_W'(N - 1);
    end else if (grant_vld) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one fixed-latency pipelined FP multiplier among N_REQ requesters, one grant per cycle.
// Handshake to response is 1+MUL_LATENCY cycles; responses cannot be back-pressured.
module fp_mul_arbiter
  import fp_pkg::*;
#(
  parameter int PRECISION   = SP_PRECISION,
  parameter int N_REQ       = 4,
  parameter int MUL_LATENCY = 2,
  parameter int IDX_W       = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*PRECISION-1:0]    req_a,
  input  logic [N_REQ*PRECISION-1:0]    req_b,
  output logic [PRECISION-1:0]          mul_a,
  output logic [PRECISION-1:0]          mul_b,
  input  logic [PRECISION-1:0]          mul_result,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [PRECISION-1:0]          rsp_data,
  output logic [IDX_W+MUL_LATENCY-1:0]  in_flight,
  output logic                          busy
);

  localparam int CNT_W = IDX_W + MUL_LATENCY;

  logic                   grant_vld;
  logic [IDX_W-1:0]       grant_idx;
  logic [MUL_LATENCY-1:0] trk_vld;
  logic [IDX_W-1:0]       trk_idx [MUL_LATENCY];
  logic                   ret_vld;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign ret_vld = |rsp_valid;

  // The tracker's last stage lines up one cycle ahead of mul_result, so rsp_valid
  // is registered from it to land in the same cycle as the product.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a     <= FP_ZERO[PRECISION-1:0];
      mul_b     <= FP_ZERO[PRECISION-1:0];
      trk_vld   <= '0;
      rsp_valid <= '0;
      in_flight <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) trk_idx[k] <= '0;
    end else begin
      if (grant_vld) begin
        mul_a <= req_a[grant_idx*PRECISION +: PRECISION];
        mul_b <= req_b[grant_idx*PRECISION +: PRECISION];
      end
      trk_vld[0] <= grant_vld;
      trk_idx[0] <= grant_idx;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        trk_vld[k] <= trk_vld[k-1];
        trk_idx[k] <= trk_idx[k-1];
      end
      rsp_valid <= '0;
      if (trk_vld[MUL_LATENCY-1]) rsp_valid[trk_idx[MUL_LATENCY-1]] <= 1'b1;
      if (grant_vld && !ret_vld)      in_flight <= in_flight + CNT_W'(1);
      else if (!grant_vld && ret_vld) in_flight <= in_flight - CNT_W'(1);
    end
  end

  assign rsp_data = mul_result;
  assign busy     = (in_flight != '0);

endmodule
